sample0_dot_acc: RTL

Dot-product accumulator sitting directly downstream of the sample0 signed 13-bit pipelined multiplier. It issues a valid tag alongside each operand pair the multiplier accepts and delays that tag by the multiplier latency. It sums VEC_LEN signed products into a wide accumulator and presents each finished sum on a valid/ready output port to the activation stage.

---
 rtl/sample0_dot_acc_if.sv | 40 ++++
 rtl/sample0_dot_acc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sample0_dot_acc_if.sv
// ---------------------------------------------------------------------------
// sample0_dot_acc_if
// Handshake and data bundle between the sample0 multiplier, the dot-product
// accumulator and the downstream activation stage.
//
// Signals:
//   ce         shared clock enable (multiplier + accumulator)
//   in_valid   operand pair presented to the multiplier
//   in_ready   accumulator accepts an operand pair
//   prod       signed multiplier product, DIN_WIDTH bits
//   out_valid  finished dot product available
//   out_ready  consumer accepts the result
//   out_data   signed dot-product result, ACC_WIDTH bits
//   sat_flag   result was saturated
//
// Modports: master = upstream/consumer side, slave = accumulator side.
// ---------------------------------------------------------------------------
interface sample0_dot_acc_if #(
    parameter int DIN_WIDTH = 13,
    parameter int ACC_WIDTH = 24
);
    logic                        ce;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [DIN_WIDTH-1:0] prod;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic                        sat_flag;

    modport master (
        output ce, in_valid, prod, out_ready,
        input  in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  ce, in_valid, prod, out_ready,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/sample0_dot_acc.sv
// ---------------------------------------------------------------------------
// sample0_dot_acc
// Dot-product accumulator behind the sample0 pipelined multiplier. Tags each
// accepted operand pair, delays the tag by MUL_LATENCY enabled cycles so it
// lines up with the product, sums VEC_LEN products and holds the result on a
// valid/ready port until the consumer takes it.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    sample0_dot_acc_if.slave (ce, in_valid/in_ready, prod,
//          out_valid/out_ready, out_data, sat_flag)
//
// Build option: define SAMPLE0_DOT_ACC_SAT_EN to saturate every add and
// report a sticky per-vector saturation bit on sat_flag. Without it the
// accumulator wraps modulo 2^ACC_WIDTH and sat_flag is tied low.
// ---------------------------------------------------------------------------
module sample0_dot_acc #(
    parameter int DIN_WIDTH   = 13,
    parameter int ACC_WIDTH   = 24,
    parameter int VEC_LEN     = 16,
    parameter int MUL_LATENCY = 2
) (
    input logic              clk,
    input logic              reset,
    sample0_dot_acc_if.slave bus
);
    localparam int CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t                      state;
    logic [CNT_W-1:0]            issue_cnt;
    logic [CNT_W-1:0]            prod_cnt;
    logic [MUL_LATENCY-1:0]      vld_p;
    logic                        pv;
    logic                        accept;
    logic                        in_ready_r;
    logic                        out_valid_r;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] sum_p;
    logic signed [ACC_WIDTH-1:0] out_data_r;

`ifdef SAMPLE0_DOT_ACC_SAT_EN
    logic signed [ACC_WIDTH:0]   wide_sum;
    logic                        sum_ovf;
    logic                        sat_sticky;
    logic                        sat_flag_r;

    // One guard bit is enough to see overflow of a two-operand add.
    function automatic logic signed [ACC_WIDTH:0] wide_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        return (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_clip(
        input logic signed [ACC_WIDTH:0] s
    );
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return s[ACC_WIDTH-1:0];
    endfunction
`endif

    assign accept   = bus.ce && bus.in_valid && in_ready_r;
    assign pv       = vld_p[MUL_LATENCY-1];
    assign prod_ext = ACC_WIDTH'(bus.prod);

`ifdef SAMPLE0_DOT_ACC_SAT_EN
    always_comb begin
        wide_sum = wide_add(acc, prod_ext);
        sum_ovf  = wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1];
        sum_p    = sat_clip(wide_sum);
    end
`else
    always_comb begin
        sum_p = acc + prod_ext;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ACCUM;
            issue_cnt   <= '0;
            prod_cnt    <= '0;
            vld_p       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            acc         <= '0;
            out_data_r  <= '0;
`ifdef SAMPLE0_DOT_ACC_SAT_EN
            sat_sticky  <= 1'b0;
            sat_flag_r  <= 1'b0;
`endif
        end else if (bus.ce) begin
            // Tag delay line: the last stage marks prod as valid this cycle.
            vld_p[0] <= accept;
            for (int i = 1; i < MUL_LATENCY; i++)
                vld_p[i] <= vld_p[i-1];

            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (issue_cnt == LAST) begin
                            issue_cnt  <= '0;
                            in_ready_r <= 1'b0;
                            state      <= DRAIN;
                        end else begin
                            issue_cnt <= issue_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase

            // The final product can only arrive in DRAIN, so the HOLD
            // assignments below never collide with the handshake above.
            if (pv) begin
                if (prod_cnt == LAST) begin
                    out_data_r  <= sum_p;
                    out_valid_r <= 1'b1;
                    state       <= HOLD;
                    acc         <= '0;
                    prod_cnt    <= '0;
`ifdef SAMPLE0_DOT_ACC_SAT_EN
                    sat_flag_r  <= sat_sticky | sum_ovf;
                    sat_sticky  <= 1'b0;
`endif
                end else if (prod_cnt == '0) begin
                    acc      <= prod_ext;
                    prod_cnt <= prod_cnt + 1'b1;
                end else begin
                    acc      <= sum_p;
                    prod_cnt <= prod_cnt + 1'b1;
`ifdef SAMPLE0_DOT_ACC_SAT_EN
                    sat_sticky <= sat_sticky | sum_ovf;
`endif
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
`ifdef SAMPLE0_DOT_ACC_SAT_EN
    assign bus.sat_flag  = sat_flag_r;
`else
    assign bus.sat_flag  = 1'b0;
`endif

endmodule
